// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: bypass selects, architectural register ids and
// the per-stage hazard tracking slot.
package pipeline_pkg;

   localparam int unsigned REG_W = 5;

   localparam logic [1:0] BYP_RF = 2'd0;
   localparam logic [1:0] BYP_XM = 2'd1;
   localparam logic [1:0] BYP_MW = 2'd2;

   localparam logic [REG_W-1:0] REG_ZERO   = 5'd0;
   localparam logic [REG_W-1:0] REG_STATUS = 5'd30;
   localparam logic [REG_W-1:0] REG_JAL    = 5'd31;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
      logic             writes;
      logic             lw;
      logic             muldiv;
      logic [REG_W-1:0] dep_a;
      logic [REG_W-1:0] dep_b;
      logic             needs_a;
      logic             needs_b;
   } slot_t;

   // Forwarding source for one X operand; the younger M result wins over W.
   function automatic logic [1:0] byp_sel(input slot_t m, input slot_t w,
                                          input logic [REG_W-1:0] src);
      logic [1:0] sel;
      sel = BYP_RF;
      if (m.valid && m.writes && (m.dest != REG_ZERO) && (m.dest == src)) begin
         sel = BYP_XM;
      end else if (w.valid && w.writes && (w.dest != REG_ZERO) && (w.dest == src)) begin
         sel = BYP_MW;
      end
      return sel;
   endfunction

endpackage

// File: rtl/muldiv_counter.sv
// Remaining-cycle counter for a mul/div occupying the X stage.
module muldiv_counter #(
   parameter int unsigned CYCLES = 32
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic clear_i,
   input  logic active_i,
   output logic busy_o,
   output logic done_o
);

   localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      busy_o = active_i && (cnt_q != '0);
      done_o = active_i && (cnt_q == '0);
      cnt_d  = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (busy_o) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard tracker: load-use and mul/div stalls plus X-stage
// operand bypass selects from the X/M/W in-flight slots.
module hazard_scoreboard
   import pipeline_pkg::*;
#(
   parameter int unsigned MULDIV_CYCLES = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             d_valid,
   input  logic             d_modifies_reg,
   input  logic [REG_W-1:0] d_modifying_reg,
   input  logic [REG_W-1:0] d_dep_a,
   input  logic [REG_W-1:0] d_dep_b,
   input  logic             d_needs_a,
   input  logic             d_needs_b,
   input  logic             d_lw,
   input  logic             d_muldiv,
   input  logic             flush,
   output logic             stall,
   output logic [1:0]       bypass_a,
   output logic [1:0]       bypass_b,
   output logic             muldiv_busy,
   output logic             muldiv_done
);

   slot_t x_q, m_q, w_q;
   slot_t x_d, m_d, w_d;
   slot_t d_slot;
   logic  load_use;
   logic  md_busy;
   logic  md_done;
   logic  md_load;
   logic  unused_ok;

   muldiv_counter #(.CYCLES(MULDIV_CYCLES)) u_muldiv_counter (
      .clk_i    (clock),
      .rst_i    (reset),
      .load_i   (md_load),
      .clear_i  (flush),
      .active_i (x_q.valid && x_q.muldiv),
      .busy_o   (md_busy),
      .done_o   (md_done)
   );

   // D entry as it would land in X; bubbles carry all-zero fields.
   always_comb begin
      d_slot = '0;
      if (d_valid) begin
         d_slot.valid   = 1'b1;
         d_slot.dest    = d_modifying_reg;
         d_slot.writes  = d_modifies_reg;
         d_slot.lw      = d_lw;
         d_slot.muldiv  = d_muldiv;
         d_slot.dep_a   = d_dep_a;
         d_slot.dep_b   = d_dep_b;
         d_slot.needs_a = d_needs_a;
         d_slot.needs_b = d_needs_b;
      end
   end

   // Stall/bypass outputs and next slot contents.
   always_comb begin
      load_use = 1'b0;
      x_d      = x_q;
      m_d      = x_q;
      w_d      = m_q;
      md_load  = 1'b0;

      if (x_q.valid && x_q.lw && x_q.writes && (x_q.dest != REG_ZERO) && d_valid
          && !md_busy) begin
         load_use = (d_needs_a && (d_dep_a == x_q.dest))
                 || (d_needs_b && (d_dep_b == x_q.dest));
      end

      stall       = !flush && (md_busy || load_use);
      muldiv_busy = md_busy;
      muldiv_done = md_done;
      bypass_a    = byp_sel(m_q, w_q, x_q.dep_a);
      bypass_b    = byp_sel(m_q, w_q, x_q.dep_b);

      if (flush) begin
         x_d = '0;
      end else if (md_busy) begin
         m_d = '0;
      end else if (load_use) begin
         x_d = '0;
      end else begin
         x_d     = d_slot;
         md_load = d_slot.valid && d_slot.muldiv;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         x_q <= x_d;
         m_q <= m_d;
         w_q <= w_d;
      end
   end

   // Not every slot field feeds a decision in every stage.
   assign unused_ok = ^{x_q, m_q, w_q};

endmodule
